// File: rtl/bon_mem_arbiter_if.sv
// Engine request/return handshakes and the pattern-memory read port of bon_mem_arbiter.
// master: the two engines plus the pattern memory; slave: the arbiter itself.
interface bon_mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 10
);
    logic              req0_en;
    logic [ADDR_W-1:0] req0_addr;
    logic              req0_gnt;
    logic              req0_vld;
    logic [DATA_W-1:0] req0_data;
    logic              fin0;

    logic              req1_en;
    logic [ADDR_W-1:0] req1_addr;
    logic              req1_gnt;
    logic              req1_vld;
    logic [DATA_W-1:0] req1_data;
    logic              fin1;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output req0_en, req0_addr, fin0, req1_en, req1_addr, fin1, mem_data,
        input  req0_gnt, req0_vld, req0_data, req1_gnt, req1_vld, req1_data,
        input  mem_en, mem_addr
    );

    modport slave (
        input  req0_en, req0_addr, fin0, req1_en, req1_addr, fin1, mem_data,
        output req0_gnt, req0_vld, req0_data, req1_gnt, req1_vld, req1_data,
        output mem_en, mem_addr
    );
endinterface

// File: rtl/bon_mem_arbiter.sv
// Round-robin sharing of one pattern-memory read port between two BON engines,
// with run sequencing (IDLE/RUN/DONE), sticky range error and saturating grant counts.
module bon_mem_arbiter #(
    parameter int DATA_W   = 10,
    parameter int ADDR_W   = 10,
    parameter int MAX_ADDR = 1023,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             eng_start,
    bon_mem_arbiter_if.slave bus,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // One extra bit so an all-ones MAX_ADDR still compares cleanly.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(MAX_ADDR);

    logic [1:0]        state;
    logic              fin0_seen;
    logic              fin1_seen;
    logic              last_gnt1;   // engine 1 was served last; engine 0 wins next conflict
    logic              vld_p1;
    logic              owner_p1;    // 1: the pending read belongs to engine 1
    logic              gnt0;
    logic              gnt1;
    logic              any_gnt;
    logic              fin_both;
    logic              run_entry;
    logic [ADDR_W-1:0] gnt_addr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Round-robin grant decision and combinational pass-through to memory.
    always_comb begin
        gnt0      = (state == ST_RUN) && bus.req0_en && (!bus.req1_en || last_gnt1);
        gnt1      = (state == ST_RUN) && bus.req1_en && (!bus.req0_en || !last_gnt1);
        any_gnt   = gnt0 | gnt1;
        gnt_addr  = gnt1 ? bus.req1_addr : bus.req0_addr;
        fin_both  = (fin0_seen | bus.fin0) & (fin1_seen | bus.fin1);
        run_entry = (state == ST_IDLE) && start;
    end

    assign bus.req0_gnt  = gnt0;
    assign bus.req1_gnt  = gnt1;
    assign bus.mem_en    = any_gnt;
    assign bus.mem_addr  = any_gnt ? gnt_addr : '0;
    assign bus.req0_vld  = vld_p1 & ~owner_p1;
    assign bus.req1_vld  = vld_p1 & owner_p1;
    assign bus.req0_data = (vld_p1 && !owner_p1) ? bus.mem_data : '0;
    assign bus.req1_data = (vld_p1 && owner_p1) ? bus.mem_data : '0;
    assign eng_start     = (state == ST_RUN);
    assign done          = (state == ST_DONE);

    // Run sequencing with sticky fin capture while running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            fin0_seen <= 1'b0;
            fin1_seen <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        fin0_seen <= 1'b0;
                        fin1_seen <= 1'b0;
                    end
                end
                ST_RUN: begin
                    fin0_seen <= fin0_seen | bus.fin0;
                    fin1_seen <= fin1_seen | bus.fin1;
                    if (fin_both) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!start) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Per-run grant counters and range error, cleared when a run begins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
            err      <= 1'b0;
        end else if (run_entry) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
            err      <= 1'b0;
        end else begin
            if (gnt0) gnt_cnt0 <= sat_inc(gnt_cnt0);
            if (gnt1) gnt_cnt1 <= sat_inc(gnt_cnt1);
            if (any_gnt && ({1'b0, gnt_addr} > ADDR_LIMIT)) err <= 1'b1;
        end
    end

    // Round-robin pointer follows every grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt1 <= 1'b1;
        end else if (any_gnt) begin
            last_gnt1 <= gnt1;
        end
    end

    // ---- stage p1: read return owner, data arrives from memory this cycle ----
    // Remember who owns the read so its data is steered back one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1   <= 1'b0;
            owner_p1 <= 1'b0;
        end else begin
            vld_p1   <= any_gnt;
            owner_p1 <= gnt1;
        end
    end
endmodule
